// File: rtl/nexys_starship_monster_ctrl_if.sv
// Game bus between the starship game logic and the monster controller.
// master drives play/spawn/shoot; slave reports monster state and stats.
interface nexys_starship_monster_ctrl_if;
  logic        play;
  logic        top_random;
  logic        btm_random;
  logic        left_random;
  logic        right_random;
  logic [3:0]  random_hex;
  logic [3:0]  shoot;
  logic [3:0]  monster;
  logic [15:0] monster_hex;
  logic        ship_hit;
  logic [1:0]  lives;
  logic [7:0]  score;
  logic        game_over;

  modport master (
    output play,
    output top_random,
    output btm_random,
    output left_random,
    output right_random,
    output random_hex,
    output shoot,
    input  monster,
    input  monster_hex,
    input  ship_hit,
    input  lives,
    input  score,
    input  game_over
  );

  modport slave (
    input  play,
    input  top_random,
    input  btm_random,
    input  left_random,
    input  right_random,
    input  random_hex,
    input  shoot,
    output monster,
    output monster_hex,
    output ship_hit,
    output lives,
    output score,
    output game_over
  );
endinterface

// File: rtl/nexys_starship_monster_ctrl.sv
// Four-direction monster spawn/kill/timeout controller with lives and score.
// Optional spawn rate limit: define NEXYS_STARSHIP_SPAWN_HOLDOFF_EN.
module nexys_starship_monster_ctrl #(
  parameter int TIMEOUT = 1000,
  parameter int HOLDOFF = 64,
  parameter int LIVES   = 3
) (
  input logic Clk,
  input logic Reset,
  nexys_starship_monster_ctrl_if.slave bus
);

  typedef enum logic {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } dir_state_t;

  dir_state_t  r_state [4];
  logic [15:0] r_age   [4];
  logic [3:0]  r_hex   [4];
  logic        r_ship_hit;
  logic [1:0]  r_lives;
  logic [7:0]  r_score;
  logic        r_game_over;

  logic [3:0]  w_active;
  logic [3:0]  w_kill;
  logic [3:0]  w_tout;
  logic [3:0]  w_req;
  logic [3:0]  w_grant;
  logic [2:0]  w_nkill;
  logic [8:0]  w_score_sum;
  logic        w_run;
  logic        w_hit;
  logic        w_lose;
  logic        w_hold_ok;
  logic        w_spawn_ok;

  assign w_run = bus.play & ~r_game_over;

  always_comb begin
    w_active = '0;
    w_tout   = '0;
    for (int i = 0; i < 4; i++) begin
      w_active[i] = (r_state[i] == ACTIVE);
    end
    w_kill = bus.shoot & w_active & {4{w_run}};
    // A kill on the timeout cycle takes precedence over the hit.
    for (int i = 0; i < 4; i++) begin
      w_tout[i] = w_active[i] & w_run & ~w_kill[i]
                & (r_age[i] == 16'(TIMEOUT - 1));
    end
  end

  assign w_hit  = |w_tout;
  assign w_lose = w_hit & (r_lives <= 2'd1);

`ifdef NEXYS_STARSHIP_SPAWN_HOLDOFF_EN
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [HW-1:0] r_holdoff;

  assign w_hold_ok = (r_holdoff == '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_holdoff <= '0;
    end else if (|w_grant) begin
      r_holdoff <= HW'(HOLDOFF);
    end else if (bus.play && r_holdoff != '0) begin
      r_holdoff <= r_holdoff - 1'b1;
    end
  end
`else
  assign w_hold_ok = (HOLDOFF >= 0);
`endif

  assign w_spawn_ok = w_run & ~w_lose & w_hold_ok;

  assign w_req = {bus.right_random, bus.left_random,
                  bus.btm_random, bus.top_random}
               & ~w_active & {4{w_spawn_ok}};

  // Isolate the lowest set bit: top has the highest priority.
  assign w_grant = w_req & (~w_req + 4'd1);

  assign w_nkill     = 3'($countones(w_kill));
  assign w_score_sum = {1'b0, r_score} + {6'd0, w_nkill};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= EMPTY;
        r_age[i]   <= '0;
        r_hex[i]   <= '0;
      end
      r_ship_hit  <= 1'b0;
      r_lives     <= 2'(LIVES);
      r_score     <= '0;
      r_game_over <= 1'b0;
    end else begin
      r_ship_hit <= w_hit;
      if (w_hit) begin
        r_lives <= (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
      end
      if (w_lose) begin
        r_game_over <= 1'b1;
      end
      if (|w_kill) begin
        r_score <= w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
      end
      for (int i = 0; i < 4; i++) begin
        unique case (r_state[i])
          EMPTY: begin
            if (w_grant[i]) begin
              r_state[i] <= ACTIVE;
              r_age[i]   <= '0;
              r_hex[i]   <= bus.random_hex;
            end
          end
          ACTIVE: begin
            if (r_game_over || w_lose || w_kill[i] || w_tout[i]) begin
              r_state[i] <= EMPTY;
              r_age[i]   <= '0;
              r_hex[i]   <= '0;
            end else if (bus.play) begin
              r_age[i] <= r_age[i] + 16'd1;
            end
          end
          default: begin
            r_state[i] <= EMPTY;
          end
        endcase
      end
    end
  end

  assign bus.monster     = w_active;
  assign bus.monster_hex = {r_hex[3], r_hex[2], r_hex[1], r_hex[0]};
  assign bus.ship_hit    = r_ship_hit;
  assign bus.lives       = r_lives;
  assign bus.score       = r_score;
  assign bus.game_over   = r_game_over;

endmodule

// File: tb/tb_nexys_starship_monster_ctrl.sv
// Directed bench for the monster controller: spawn, kill, timeout,
// freeze, game over, reset and spawn holdoff behaviour.
module tb_nexys_starship_monster_ctrl;

  localparam int TIMEOUT = 1000;
  localparam int HOLDOFF = 64;
`ifdef NEXYS_STARSHIP_SPAWN_HOLDOFF_EN
  localparam int HO = HOLDOFF;
  localparam bit HO_EN = 1'b1;
`else
  localparam int HO = 0;
  localparam bit HO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  nexys_starship_monster_ctrl_if bus ();

  nexys_starship_monster_ctrl #(
    .TIMEOUT (TIMEOUT),
    .HOLDOFF (HOLDOFF),
    .LIVES   (3)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_req();
    bus.top_random   = 1'b0;
    bus.btm_random   = 1'b0;
    bus.left_random  = 1'b0;
    bus.right_random = 1'b0;
    bus.shoot        = 4'd0;
  endtask

  task automatic spawn(input logic [3:0] dirs, input logic [3:0] hex);
    bus.top_random   = dirs[0];
    bus.btm_random   = dirs[1];
    bus.left_random  = dirs[2];
    bus.right_random = dirs[3];
    bus.random_hex   = hex;
    step(1);
    clr_req();
  endtask

  task automatic shoot(input logic [3:0] dirs);
    bus.shoot = dirs;
    step(1);
    bus.shoot = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.play = 1'b1;
    bus.top_random = 1'b1;
    bus.shoot = 4'b1111;
    bus.random_hex = 4'hF;
    step(2);
    rst = 1'b0;
    clr_req();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.play = 1'b0;
    bus.random_hex = 4'h0;
    clr_req();
    step(1);
    do_reset();
    chk("rst_monster", bus.monster, 4'd0);
    chk("rst_hex", bus.monster_hex, 16'h0);
    chk("rst_hit", bus.ship_hit, 1'b0);
    chk("rst_lives", bus.lives, 2'd3);
    chk("rst_score", bus.score, 8'd0);
    chk("rst_go", bus.game_over, 1'b0);

    spawn(4'b0001, 4'hA);
    chk("spawn_top", bus.monster, 4'b0001);
    chk("spawn_top_hex", bus.monster_hex, 16'h000A);
    shoot(4'b0001);
    chk("kill_top", bus.monster, 4'd0);
    chk("kill_top_hex", bus.monster_hex, 16'h0);
    chk("kill_score", bus.score, 8'd1);
    shoot(4'b0100);
    chk("empty_shot", bus.score, 8'd1);

    step(HO);
    spawn(4'b0101, 4'h5);
    chk("prio_top_left", bus.monster, 4'b0001);
    chk("prio_hex", bus.monster_hex, 16'h0005);
    shoot(4'b0001);
    chk("kill2", bus.monster, 4'd0);
    chk("kill2_score", bus.score, 8'd2);

    step(HO);
    spawn(4'b1010, 4'h7);
    chk("prio_btm_right", bus.monster, 4'b0010);
    chk("btm_hex", bus.monster_hex, 16'h0070);
    step(TIMEOUT - 1);
    chk("btm_pre_to_hit", bus.ship_hit, 1'b0);
    chk("btm_pre_to_mon", bus.monster, 4'b0010);
    step(1);
    chk("btm_to_hit", bus.ship_hit, 1'b1);
    chk("btm_to_mon", bus.monster, 4'd0);
    chk("btm_to_lives", bus.lives, 2'd2);
    chk("btm_to_hex", bus.monster_hex, 16'h0);
    step(1);
    chk("hit_pulse", bus.ship_hit, 1'b0);

    step(HO);
    spawn(4'b0001, 4'h3);
    step(TIMEOUT - 1);
    shoot(4'b0001);
    chk("tie_hit", bus.ship_hit, 1'b0);
    chk("tie_score", bus.score, 8'd3);
    chk("tie_mon", bus.monster, 4'd0);
    chk("tie_lives", bus.lives, 2'd2);

    step(HO);
    spawn(4'b0100, 4'hC);
    bus.play = 1'b0;
    step(250);
    bus.right_random = 1'b1;
    step(1);
    bus.right_random = 1'b0;
    step(249);
    chk("frz_mon", bus.monster, 4'b0100);
    chk("frz_hex", bus.monster_hex, 16'h0C00);
    chk("frz_hit", bus.ship_hit, 1'b0);
    bus.play = 1'b1;
    step(TIMEOUT - 1);
    chk("frz_pre_hit", bus.ship_hit, 1'b0);
    step(1);
    chk("frz_hit2", bus.ship_hit, 1'b1);
    chk("frz_lives", bus.lives, 2'd1);

    step(HO);
    spawn(4'b0001, 4'h1);
    spawn(4'b0010, 4'h2);
    step(TIMEOUT - 2);
    chk("go_pre", bus.game_over, 1'b0);
    step(1);
    chk("go_hit", bus.ship_hit, 1'b1);
    chk("go_lives", bus.lives, 2'd0);
    chk("go_flag", bus.game_over, 1'b1);
    chk("go_mon", bus.monster, 4'd0);
    spawn(4'b1000, 4'h9);
    chk("go_no_spawn", bus.monster, 4'd0);
    chk("go_no_hex", bus.monster_hex, 16'h0);
    chk("go_score", bus.score, 8'd3);
    chk("go_sticky", bus.game_over, 1'b1);

    do_reset();
    chk("rst2_lives", bus.lives, 2'd3);
    chk("rst2_go", bus.game_over, 1'b0);
    spawn(4'b0001, 4'h4);
    step(10);
    spawn(4'b0010, 4'h6);
    chk("ho_second", bus.monster[1], HO_EN ? 1'b0 : 1'b1);
    step(52);
    spawn(4'b0100, 4'h8);
    chk("ho_edge", bus.monster[2], HO_EN ? 1'b0 : 1'b1);
    spawn(4'b1000, 4'hB);
    chk("ho_after", bus.monster[3], 1'b1);
    chk("ho_hex", bus.monster_hex[15:12], 4'hB);

    bus.shoot = 4'b1000;
    step(1);
    bus.shoot = 4'd0;
    chk("mid_score", bus.score, 8'd1);
    do_reset();
    chk("mid_rst_mon", bus.monster, 4'd0);
    chk("mid_rst_hex", bus.monster_hex, 16'h0);
    chk("mid_rst_score", bus.score, 8'd0);
    chk("mid_rst_hit", bus.ship_hit, 1'b0);

    for (int k = 0; k < 255; k++) begin
      spawn(4'b0001, 4'h1);
      shoot(4'b0001);
      step(HO);
    end
    chk("score_255", bus.score, 8'd255);
    spawn(4'b0001, 4'h1);
    shoot(4'b0001);
    chk("score_sat", bus.score, 8'd255);
    chk("score_sat_mon", bus.monster, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
